// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_pkg
// Purpose  : Shared memory-port definitions: address/data widths, the
//            conflict counter width and limit, and the arbiter state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ram_port_arbiter_pkg;

    localparam int c_addr_w = 10;
    localparam int c_data_w = 32;
    localparam int c_cnt_w  = 16;

    localparam logic [c_cnt_w-1:0] c_cnt_max = {c_cnt_w{1'b1}};

    // The state records which port, if any, completed an access last cycle.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_I_RESP = 2'b01,
        ST_D_RESP = 2'b10
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_port_grant.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_grant
// Purpose  : Combinational grant decision for the shared RAM port.
//            The port that completed an access last cycle is excluded, which
//            turns the fixed data priority into alternation under contention.
// Ports    : state   in  arbiter state (who completed last cycle)
//            i_req   in  instruction-fetch request
//            d_req   in  data request
//            grant_i out fetch port granted this cycle
//            grant_d out data port granted this cycle
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_grant
    import ram_port_arbiter_pkg::*;
(
    input  arb_state_t state,
    input  logic       i_req,
    input  logic       d_req,
    output logic       grant_i,
    output logic       grant_d
);

    always_comb begin
        grant_d = d_req && (state != ST_D_RESP);
        grant_i = i_req && !grant_d && (state != ST_I_RESP);
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares one single-port word RAM (built from two halfword RAMs)
//            between an instruction-fetch port and a data port. Data has
//            priority from idle; the two ports alternate under contention.
//            Read data is captured at the edge closing the grant cycle and
//            announced with a one-cycle valid pulse.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            i_req/i_addr        fetch request and word address
//            i_rdata/i_valid     registered fetch data and completion pulse
//            d_req/d_we/d_hwe    data request, write flag, halfword enables
//            d_addr/d_wdata      data word address and write data
//            d_rdata/d_valid     registered read data and completion pulse
//            ram_addr/ram_d      shared RAM address and write data
//            ram_we              RAM write strobe
//            ram_sel_hi/_lo      upper/lower halfword RAM selects
//            ram_q               asynchronous RAM read data
//            conflict_cnt        saturating count of contended idle cycles
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [c_addr_w-1:0] i_addr,
    output logic [c_data_w-1:0] i_rdata,
    output logic                i_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [1:0]          d_hwe,
    input  logic [c_addr_w-1:0] d_addr,
    input  logic [c_data_w-1:0] d_wdata,
    output logic [c_data_w-1:0] d_rdata,
    output logic                d_valid,
    output logic [c_addr_w-1:0] ram_addr,
    output logic [c_data_w-1:0] ram_d,
    output logic                ram_we,
    output logic                ram_sel_hi,
    output logic                ram_sel_lo,
    input  logic [c_data_w-1:0] ram_q,
    output logic [c_cnt_w-1:0]  conflict_cnt
);

    arb_state_t r_state;
    logic       w_grant_i;
    logic       w_grant_d;
    logic       w_wr_grant;
    logic       w_conflict;

    ram_port_grant u_grant (
        .state   (r_state),
        .i_req   (i_req),
        .d_req   (d_req),
        .grant_i (w_grant_i),
        .grant_d (w_grant_d)
    );

    always_comb begin
        w_wr_grant = w_grant_d && d_we;
        w_conflict = (r_state == ST_IDLE) && i_req && d_req;

        // The fetch address is the default so the RAM keeps reading
        // something meaningful on idle cycles.
        ram_addr   = w_grant_d ? d_addr : i_addr;
        ram_d      = d_wdata;

        // A write with no halfword enabled is acknowledged but never strobes
        // the RAM; reset gates the strobe directly so an access cut short by
        // reset cannot corrupt memory.
        ram_we     = rst_n && w_wr_grant && (d_hwe != 2'b00);
        ram_sel_hi = w_wr_grant ? d_hwe[1] : 1'b1;
        ram_sel_lo = w_wr_grant ? d_hwe[0] : 1'b1;
    end

    // Read data is sampled from ram_q at the same edge that commits a write,
    // so a write returns the pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            i_valid      <= 1'b0;
            d_valid      <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            conflict_cnt <= '0;
        end else begin
            if (w_grant_d) begin
                r_state <= ST_D_RESP;
            end else if (w_grant_i) begin
                r_state <= ST_I_RESP;
            end else begin
                r_state <= ST_IDLE;
            end

            i_valid <= w_grant_i;
            d_valid <= w_grant_d;

            if (w_grant_i) begin
                i_rdata <= ram_q;
            end
            if (w_grant_d) begin
                d_rdata <= ram_q;
            end

            if (w_conflict && (conflict_cnt != c_cnt_max)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Self-checking bench for ram_port_arbiter. Holds a behavioural
//            RAM, a transaction-level reference memory and a model of which
//            port is served each cycle; runs directed scenarios, a random
//            request phase and the counter saturation scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req, d_req, d_we;
    logic [9:0]  i_addr, d_addr;
    logic [1:0]  d_hwe;
    logic [31:0] d_wdata;
    logic [31:0] i_rdata, d_rdata, ram_d, ram_q;
    logic        i_valid, d_valid, ram_we, ram_sel_hi, ram_sel_lo;
    logic [9:0]  ram_addr;
    logic [15:0] conflict_cnt;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_valid      (i_valid),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_hwe        (d_hwe),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_valid      (d_valid),
        .ram_addr     (ram_addr),
        .ram_d        (ram_d),
        .ram_we       (ram_we),
        .ram_sel_hi   (ram_sel_hi),
        .ram_sel_lo   (ram_sel_lo),
        .ram_q        (ram_q),
        .conflict_cnt (conflict_cnt)
    );

    // Behavioural RAM: asynchronous read, halfword-selected synchronous write.
    logic [31:0] env_mem [0:1023];
    logic        clr = 1'b0;
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < 1024; k++) env_mem[k] <= '0;
        end else if (pl_en) begin
            env_mem[pl_addr] <= pl_data;
        end else if (ram_we) begin
            if (ram_sel_hi) env_mem[ram_addr][31:16] <= ram_d[31:16];
            if (ram_sel_lo) env_mem[ram_addr][15:0]  <= ram_d[15:0];
        end
    end
    assign ram_q = env_mem[ram_addr];

    // Reference model state.
    logic [31:0] ref_mem [0:1023];
    int          m_last;      // 0 none, 1 fetch served last cycle, 2 data served
    int          m_cnt;
    logic [31:0] m_i_rd, m_d_rd;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven (just after a falling edge).
    task automatic cycle();
        logic       gd, gi;
        logic [1:0] sel;
        gd = d_req && (m_last != 2);
        gi = i_req && !gd && (m_last != 1);
        #1;
        chk("ram_we", {31'd0, ram_we}, {31'd0, gd && d_we && (d_hwe != 2'b00)});
        chk("ram_addr", {22'd0, ram_addr}, {22'd0, (gd ? d_addr : i_addr)});
        sel = (gd && d_we) ? d_hwe : 2'b11;
        chk("ram_sel", {30'd0, ram_sel_hi, ram_sel_lo}, {30'd0, sel});
        chk("ram_d", ram_d, d_wdata);
        if (m_last == 0 && i_req && d_req && m_cnt < 65535) m_cnt++;
        if (gi) m_i_rd = ref_mem[i_addr];
        if (gd) begin
            m_d_rd = ref_mem[d_addr];
            if (d_we) begin
                if (d_hwe[1]) ref_mem[d_addr][31:16] = d_wdata[31:16];
                if (d_hwe[0]) ref_mem[d_addr][15:0]  = d_wdata[15:0];
            end
        end
        m_last = gd ? 2 : (gi ? 1 : 0);
        @(negedge clk);
        chk("i_valid", {31'd0, i_valid}, {31'd0, m_last == 1});
        chk("d_valid", {31'd0, d_valid}, {31'd0, m_last == 2});
        chk("i_rdata", i_rdata, m_i_rd);
        chk("d_rdata", d_rdata, m_d_rd);
        chk("conflict_cnt", {16'd0, conflict_cnt}, m_cnt);
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_hwe = 2'b11;
        i_addr = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        m_last = 0; m_cnt = 0; m_i_rd = '0; m_d_rd = '0;
        repeat (2) @(negedge clk);
        chk("rst_i_valid", {31'd0, i_valid}, 32'd0);
        chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [9:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 10'h3FF;
        return 10'($urandom_range(0, 15));
    endfunction

    initial begin
        clear_inputs();
        for (int k = 0; k < 1024; k++) ref_mem[k] = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        pl_en = 1'b1; pl_addr = 10'h005; pl_data = 32'h1234_5678;
        ref_mem[5] = 32'h1234_5678;
        @(negedge clk);
        pl_en = 1'b0;
        do_reset();

        // Fetch only.
        i_req = 1'b1; i_addr = 10'h005;
        cycle();
        chk("fetch_valid", {31'd0, i_valid}, 32'd1);
        chk("fetch_rdata", i_rdata, 32'h1234_5678);
        chk("fetch_no_dvalid", {31'd0, d_valid}, 32'd0);
        i_req = 1'b0;
        cycle();

        // Simultaneous requests from idle: data first, fetch next cycle.
        i_req = 1'b1; i_addr = 10'h006; d_req = 1'b1; d_addr = 10'h005;
        cycle();
        chk("sim_d_first", {31'd0, d_valid}, 32'd1);
        chk("sim_d_rdata", d_rdata, 32'h1234_5678);
        d_req = 1'b0;
        cycle();
        chk("sim_i_second", {31'd0, i_valid}, 32'd1);
        chk("sim_cnt", {16'd0, conflict_cnt}, 32'd1);
        i_req = 1'b0;
        cycle();

        // Upper-halfword write over zero, then read back.
        d_req = 1'b1; d_we = 1'b1; d_hwe = 2'b10; d_addr = 10'h3FF; d_wdata = 32'hAAAA_5555;
        cycle();
        chk("hw_ack", {31'd0, d_valid}, 32'd1);
        chk("hw_prewrite", d_rdata, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        cycle();
        chk("hw_ram", env_mem[10'h3FF], 32'hAAAA_0000);
        d_req = 1'b1; d_hwe = 2'b11;
        cycle();
        chk("hw_readback", d_rdata, 32'hAAAA_0000);
        d_req = 1'b0;
        cycle();

        // Null write: acknowledged, RAM untouched.
        d_req = 1'b1; d_we = 1'b1; d_hwe = 2'b00; d_addr = 10'h005; d_wdata = 32'hFFFF_FFFF;
        cycle();
        chk("null_ack", {31'd0, d_valid}, 32'd1);
        d_req = 1'b0; d_we = 1'b0; d_hwe = 2'b11;
        cycle();
        d_req = 1'b1;
        cycle();
        chk("null_unchanged", d_rdata, 32'h1234_5678);
        d_req = 1'b0;
        cycle();

        // Reset asserted in the grant cycle of a write.
        d_req = 1'b1; d_we = 1'b1; d_hwe = 2'b11; d_addr = 10'h007; d_wdata = 32'hDEAD_BEEF;
        #1;
        chk("mid_we_before", {31'd0, ram_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_we_forced", {31'd0, ram_we}, 32'd0);
        @(negedge clk);
        chk("mid_no_dvalid", {31'd0, d_valid}, 32'd0);
        chk("mid_no_ivalid", {31'd0, i_valid}, 32'd0);
        chk("mid_cnt_clr", {16'd0, conflict_cnt}, 32'd0);
        clear_inputs();
        m_last = 0; m_cnt = 0; m_i_rd = '0; m_d_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_ram_kept", env_mem[10'h007], 32'd0);
        i_req = 1'b1; d_req = 1'b1; i_addr = 10'h005; d_addr = 10'h007;
        cycle();
        chk("mid_idle_dfirst", {31'd0, d_valid}, 32'd1);
        chk("mid_idle_cnt", {16'd0, conflict_cnt}, 32'd1);
        clear_inputs();
        cycle();

        // Random traffic, requests held until served (occasionally abandoned).
        for (int c = 0; c < 3000; c++) begin
            if (m_last == 1) i_req = 1'b0;
            if (m_last == 2) d_req = 1'b0;
            if (!i_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    i_req = 1'b1; i_addr = rand_addr();
                end
            end else if ($urandom_range(0, 31) == 0) begin
                i_req = 1'b0;
            end
            if (!d_req) begin
                if ($urandom_range(0, 1) == 0) begin
                    d_req = 1'b1; d_addr = rand_addr();
                    d_we = 1'($urandom_range(0, 1));
                    d_hwe = 2'($urandom_range(0, 3));
                    d_wdata = $urandom;
                end
            end else if ($urandom_range(0, 31) == 0) begin
                d_req = 1'b0;
            end
            cycle();
        end
        clear_inputs();
        cycle();

        // Counter saturation.
        do_reset();
        for (int c = 0; c < 65540; c++) begin
            i_req = 1'b1; d_req = 1'b1; i_addr = 10'h005; d_addr = 10'h006;
            cycle();
            i_req = 1'b0; d_req = 1'b0;
            cycle();
        end
        chk("sat_value", {16'd0, conflict_cnt}, 32'h0000_FFFF);
        for (int c = 0; c < 4; c++) begin
            i_req = 1'b1; d_req = 1'b1;
            cycle();
            i_req = 1'b0; d_req = 1'b0;
            cycle();
        end
        chk("sat_hold", {16'd0, conflict_cnt}, 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
